// File: rtl/mem_line_reader.sv
// rtl/mem_line_reader.sv - mem_intf_read client: splits a read command into bursts and streams lines out of a FIFO
// Optional protocol checker on the err output: define MEM_LINE_READER_CHK_EN.
module mem_line_reader #(
   parameter int DEPTH           = 8,
   parameter int MAX_BURST_LINES = 4,
   parameter int SIZE_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [18:0]           cmd_addr,
   input  logic [SIZE_WIDTH-1:0] cmd_bytes,
   output logic                  mem_req,
   output logic [18:0]           mem_start_addr,
   output logic [SIZE_WIDTH-1:0] mem_size_bytes,
   input  logic                  mem_valid,
   input  logic [255:0]          mem_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [255:0]          out_data,
   output logic [5:0]            out_bytes,
   output logic                  out_last,
   output logic                  done,
   output logic                  err
);

   localparam int PTR_W       = $clog2(DEPTH);
   localparam int CNT_W       = PTR_W + 1;
   localparam int BEAT_W      = $clog2(MAX_BURST_LINES + 1);
   localparam int BURST_BYTES = MAX_BURST_LINES * 32;
   localparam int LINE_W      = SIZE_WIDTH - 4;

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

   state_t                state, state_nxt;
   logic [SIZE_WIDTH-1:0] rem;
   logic [18:0]           addr;
   logic [BEAT_W-1:0]     beat_cnt;

   logic [255:0]          fifo_data  [DEPTH];
   logic [5:0]            fifo_bytes [DEPTH];
   logic                  fifo_last  [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;

   logic [SIZE_WIDTH-1:0] burst_bytes;
   logic [SIZE_WIDTH:0]   lines_round;
   logic [LINE_W-1:0]     burst_lines;
   logic [CNT_W-1:0]      occ_after_pop;
   logic [CNT_W-1:0]      free;
   logic                  space_ok;
   logic                  beat_ok;
   logic                  push, pop;
   logic                  burst_end;
   logic                  cmd_final_line;
   logic [5:0]            push_bytes;
   logic [SIZE_WIDTH-1:0] rem_after;

   always_comb begin
      burst_bytes = (rem < SIZE_WIDTH'(BURST_BYTES)) ? rem : SIZE_WIDTH'(BURST_BYTES);
      lines_round = {1'b0, burst_bytes} + (SIZE_WIDTH+1)'(31);
      burst_lines = LINE_W'(lines_round >> 5);
   end

   // Free space is judged after this cycle's pop so a draining consumer is not penalised.
   assign pop           = out_ready && (count != '0);
   assign occ_after_pop = count - CNT_W'(pop);
   assign free          = CNT_W'(DEPTH) - occ_after_pop;
   assign space_ok      = (LINE_W'(free) >= burst_lines);

`ifdef MEM_LINE_READER_CHK_EN
   logic req_seen;
   logic err_q;

   // A beat in the first mem_req cycle answers a request the memory could not yet have seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_seen <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         req_seen <= (state == REQ);
         if (mem_valid && !((state == REQ) && req_seen))
            err_q <= 1'b1;
      end
   end

   assign beat_ok = mem_valid && (state == REQ) && req_seen;
   assign err     = err_q;
`else
   assign beat_ok = mem_valid && (state == REQ);
   assign err     = 1'b0;
`endif

   assign push           = beat_ok;
   assign burst_end      = push && (beat_cnt == BEAT_W'(1));
   assign cmd_final_line = burst_end && (rem == mem_size_bytes);
   assign rem_after      = rem - mem_size_bytes;

   always_comb begin
      push_bytes = 6'd32;
      if (cmd_final_line && (mem_size_bytes[4:0] != 5'd0))
         push_bytes = {1'b0, mem_size_bytes[4:0]};
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid)
               state_nxt = (cmd_bytes == '0) ? DONE : GAP;
         end
         GAP: begin
            if (space_ok)
               state_nxt = REQ;
         end
         REQ: begin
            if (burst_end)
               state_nxt = (rem_after != '0) ? GAP : DONE;
         end
         DONE: begin
            if (count == '0) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         rem            <= '0;
         addr           <= '0;
         mem_start_addr <= '0;
         mem_size_bytes <= '0;
         beat_cnt       <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  rem  <= cmd_bytes;
                  addr <= cmd_addr;
               end
            end
            GAP: begin
               if (space_ok) begin
                  mem_start_addr <= addr;
                  mem_size_bytes <= burst_bytes;
                  beat_cnt       <= BEAT_W'(burst_lines);
               end
            end
            REQ: begin
               if (push)
                  beat_cnt <= beat_cnt - BEAT_W'(1);
               if (burst_end) begin
                  addr <= addr + 19'(mem_size_bytes);
                  rem  <= rem_after;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr]  <= mem_data;
         fifo_bytes[wr_ptr] <= push_bytes;
         fifo_last[wr_ptr]  <= cmd_final_line;
      end
   end

   assign cmd_ready = (state == IDLE);
   assign mem_req   = (state == REQ);
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? fifo_data[rd_ptr]  : '0;
   assign out_bytes = out_valid ? fifo_bytes[rd_ptr] : '0;
   assign out_last  = out_valid ? fifo_last[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_mem_line_reader.sv
// tb/tb_mem_line_reader.sv - directed bench for mem_line_reader with a memory responder and stream monitor
module tb_mem_line_reader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [18:0]  cmd_addr = '0;
   logic [15:0]  cmd_bytes = '0;
   logic         mem_req;
   logic [18:0]  mem_start_addr;
   logic [15:0]  mem_size_bytes;
   logic         mem_valid = 1'b0;
   logic [255:0] mem_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] out_data;
   logic [5:0]   out_bytes;
   logic         out_last;
   logic         done;
   logic         err;

   mem_line_reader #(.DEPTH(8), .MAX_BURST_LINES(4), .SIZE_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
      .mem_req(mem_req), .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
      .mem_valid(mem_valid), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_bytes(out_bytes), .out_last(out_last),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ready_mode = 1;
   int max_gap = 0;
   int beat_limit = 32'h7fffffff;
   int beats_sent = 0;
   int stray_req = 0;
   int stray_sent = 0;

   logic [255:0] line_d [$];
   logic [5:0]   line_b [$];
   logic         line_l [$];
   logic [18:0]  req_a [$];
   logic [15:0]  req_s [$];
   int           req_c [$];
   int           done_cnt = 0;
   int           stab_err = 0;
   int           ov_cnt = 0;

   function automatic logic [255:0] pat(input logic [18:0] a);
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = {8'(i + 160), 5'd0, a};
      return d;
   endfunction

   initial begin : responder
      logic [18:0] r_addr;
      int          r_left;
      int          r_gap;
      logic        r_prev;
      r_addr = '0; r_left = 0; r_gap = 0; r_prev = 1'b0;
      forever begin
         @(posedge clk); #1;
         mem_valid = 1'b0;
         if (stray_sent < stray_req) begin
            mem_valid = 1'b1;
            mem_data  = pat(19'h7abcd);
            stray_sent++;
         end else if (!mem_req) begin
            r_left = 0;
         end else if (!r_prev) begin
            r_left = (int'(mem_size_bytes) + 31) / 32;
            r_addr = mem_start_addr;
            r_gap  = 0;
         end else if (r_left > 0 && beats_sent < beat_limit) begin
            if (r_gap > 0) r_gap--;
            else begin
               mem_valid = 1'b1;
               mem_data  = pat(r_addr);
               r_addr    = r_addr + 19'd32;
               r_left--;
               beats_sent++;
               r_gap = $urandom_range(0, max_gap);
            end
         end
         r_prev = mem_req;
      end
   end

   initial begin : consumer
      forever begin
         @(posedge clk); #1;
         if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
         else out_ready = (ready_mode == 1);
      end
   end

   initial begin : monitor
      logic        m_prev;
      logic [18:0] m_a;
      logic [15:0] m_s;
      m_prev = 1'b0; m_a = '0; m_s = '0;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            line_d.push_back(out_data);
            line_b.push_back(out_bytes);
            line_l.push_back(out_last);
         end
         if (out_valid) ov_cnt++;
         if (done) done_cnt++;
         if (mem_req && !m_prev) begin
            req_a.push_back(mem_start_addr);
            req_s.push_back(mem_size_bytes);
            req_c.push_back(cyc);
         end else if (mem_req && (mem_start_addr !== m_a || mem_size_bytes !== m_s)) begin
            stab_err++;
         end
         m_prev = mem_req; m_a = mem_start_addr; m_s = mem_size_bytes;
      end
   end

   task automatic issue(input logic [18:0] a, input logic [15:0] n, output int acc);
      @(posedge clk); #1;
      cmd_addr = a; cmd_bytes = n; cmd_valid = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (done_cnt > base) begin ok = 1'b1; break; end
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
      vectors++; if (mem_size_bytes !== 16'd0) begin miscompares++; $display("FAIL reset_size: got %0d want 0", mem_size_bytes); end
      vectors++; if (out_data !== 256'd0) begin miscompares++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
   endtask

   task automatic test_single();
      int rb, lb, db, acc; bit ok;
      rb = req_a.size(); lb = line_d.size(); db = done_cnt;
      ready_mode = 1; max_gap = 0;
      issue(19'h100, 16'd64, acc);
      wait_done(db, 200, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL single_done_timeout: got none want pulse"); end
      vectors++; if (req_a.size() - rb !== 1) begin miscompares++; $display("FAIL single_req_count: got %0d want 1", req_a.size() - rb); end
      if (req_a.size() > rb) begin
         vectors++; if (req_a[rb] !== 19'h100) begin miscompares++; $display("FAIL single_req_addr: got %0h want 100", req_a[rb]); end
         vectors++; if (req_s[rb] !== 16'd64) begin miscompares++; $display("FAIL single_req_size: got %0d want 64", req_s[rb]); end
         vectors++; if (req_c[rb] - acc !== 1) begin miscompares++; $display("FAIL single_req_latency: got %0d want 1", req_c[rb] - acc); end
      end
      vectors++; if (line_d.size() - lb !== 2) begin miscompares++; $display("FAIL single_line_count: got %0d want 2", line_d.size() - lb); end
      if (line_d.size() >= lb + 2) begin
         vectors++; if (line_d[lb] !== pat(19'h100)) begin miscompares++; $display("FAIL single_data0: got %0h want %0h", line_d[lb], pat(19'h100)); end
         vectors++; if (line_d[lb+1] !== pat(19'h120)) begin miscompares++; $display("FAIL single_data1: got %0h want %0h", line_d[lb+1], pat(19'h120)); end
         vectors++; if (line_l[lb] !== 1'b0 || line_b[lb] !== 6'd32) begin miscompares++; $display("FAIL single_line0_tag: got last=%b bytes=%0d want 0/32", line_l[lb], line_b[lb]); end
         vectors++; if (line_l[lb+1] !== 1'b1 || line_b[lb+1] !== 6'd32) begin miscompares++; $display("FAIL single_line1_tag: got last=%b bytes=%0d want 1/32", line_l[lb+1], line_b[lb+1]); end
      end
      vectors++; if (done_cnt - db !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d want 1", done_cnt - db); end
   endtask

   task automatic test_multi_burst();
      int rb, lb, db, acc; bit ok;
      rb = req_a.size(); lb = line_d.size(); db = done_cnt;
      ready_mode = 1; max_gap = 0;
      issue(19'h0, 16'd200, acc);
      wait_done(db, 300, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL multi_done_timeout: got none want pulse"); end
      vectors++; if (req_a.size() - rb !== 2) begin miscompares++; $display("FAIL multi_req_count: got %0d want 2", req_a.size() - rb); end
      if (req_a.size() >= rb + 2) begin
         vectors++; if (req_a[rb] !== 19'h0 || req_s[rb] !== 16'd128) begin miscompares++; $display("FAIL multi_req0: got %0h/%0d want 0/128", req_a[rb], req_s[rb]); end
         vectors++; if (req_a[rb+1] !== 19'h80 || req_s[rb+1] !== 16'd72) begin miscompares++; $display("FAIL multi_req1: got %0h/%0d want 80/72", req_a[rb+1], req_s[rb+1]); end
      end
      vectors++; if (line_d.size() - lb !== 7) begin miscompares++; $display("FAIL multi_line_count: got %0d want 7", line_d.size() - lb); end
      for (int k = 0; k < 7; k++) begin
         if (lb + k < line_d.size()) begin
            vectors++;
            if (line_d[lb+k] !== pat(19'(k*32)) || line_l[lb+k] !== (k == 6) || line_b[lb+k] !== ((k == 6) ? 6'd8 : 6'd32)) begin
               miscompares++;
               $display("FAIL multi_line%0d: got last=%b bytes=%0d data=%0h", k, line_l[lb+k], line_b[lb+k], line_d[lb+k]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int rb, lb, db, acc; bit ok;
      logic [18:0] exp_a [3];
      logic [15:0] exp_s [3];
      exp_a[0] = 19'h2000; exp_a[1] = 19'h2080; exp_a[2] = 19'h2100;
      exp_s[0] = 16'd128;  exp_s[1] = 16'd128;  exp_s[2] = 16'd64;
      rb = req_a.size(); lb = line_d.size(); db = done_cnt;
      ready_mode = 0; max_gap = 0;
      issue(19'h2000, 16'd320, acc);
      repeat (40) @(posedge clk);
      #2;
      vectors++; if (req_a.size() - rb !== 2) begin miscompares++; $display("FAIL bp_stall_reqs: got %0d want 2", req_a.size() - rb); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_stall_mem_req: got %b want 0", mem_req); end
      vectors++; if (out_valid !== 1'b1 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall_state: got ov=%b rdy=%b want 1/0", out_valid, cmd_ready); end
      ready_mode = 1;
      wait_done(db, 400, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL bp_done_timeout: got none want pulse"); end
      vectors++; if (req_a.size() - rb !== 3) begin miscompares++; $display("FAIL bp_req_count: got %0d want 3", req_a.size() - rb); end
      for (int i = 0; i < 3; i++) begin
         if (rb + i < req_a.size()) begin
            vectors++;
            if (req_a[rb+i] !== exp_a[i] || req_s[rb+i] !== exp_s[i]) begin
               miscompares++; $display("FAIL bp_req%0d: got %0h/%0d want %0h/%0d", i, req_a[rb+i], req_s[rb+i], exp_a[i], exp_s[i]);
            end
         end
      end
      vectors++; if (line_d.size() - lb !== 10) begin miscompares++; $display("FAIL bp_line_count: got %0d want 10", line_d.size() - lb); end
      for (int k = 0; k < 10; k++) begin
         if (lb + k < line_d.size()) begin
            vectors++;
            if (line_d[lb+k] !== pat(19'h2000 + 19'(k*32)) || line_l[lb+k] !== (k == 9) || line_b[lb+k] !== 6'd32) begin
               miscompares++; $display("FAIL bp_line%0d: got last=%b bytes=%0d data=%0h", k, line_l[lb+k], line_b[lb+k], line_d[lb+k]);
            end
         end
      end
   endtask

   task automatic test_zero();
      int rb, lb, db, ob, acc; bit ok;
      rb = req_a.size(); lb = line_d.size(); db = done_cnt; ob = ov_cnt;
      ready_mode = 1;
      issue(19'h55, 16'd0, acc);
      wait_done(db, 20, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL zero_done_timeout: got none want pulse"); end
      vectors++; if (done_cnt - db !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - db); end
      vectors++; if (req_a.size() - rb !== 0) begin miscompares++; $display("FAIL zero_reqs: got %0d want 0", req_a.size() - rb); end
      vectors++; if (ov_cnt - ob !== 0 || line_d.size() - lb !== 0) begin miscompares++; $display("FAIL zero_out_valid: got %0d cycles want 0", ov_cnt - ob); end
      vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL zero_cmd_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_reset_mid();
      int rb, lb, ob, acc, waited; logic exp_err;
`ifdef MEM_LINE_READER_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      ready_mode = 1; max_gap = 0;
      beat_limit = beats_sent + 2;
      lb = line_d.size();
      issue(19'h400, 16'd128, acc);
      waited = 0;
      while (line_d.size() - lb < 2 && waited < 100) begin @(posedge clk); #2; waited++; end
      vectors++; if (line_d.size() - lb !== 2) begin miscompares++; $display("FAIL rstmid_pre_lines: got %0d want 2", line_d.size() - lb); end
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_req: got %b want 1", mem_req); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      rb = req_a.size(); lb = line_d.size(); ob = ov_cnt;
      vectors++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_after: got req=%b ov=%b rdy=%b want 0/0/1", mem_req, out_valid, cmd_ready);
      end
      beat_limit = 32'h7fffffff;
      stray_req = stray_sent + 2;
      repeat (6) @(posedge clk);
      #2;
      vectors++; if (ov_cnt - ob !== 0 || line_d.size() - lb !== 0) begin miscompares++; $display("FAIL rstmid_stray_lines: got %0d valid cycles want 0", ov_cnt - ob); end
      vectors++; if (req_a.size() - rb !== 0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_stray_req: got %0d reqs want 0", req_a.size() - rb); end
      vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL rstmid_err: got %b want %b", err, exp_err); end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rstmid_err_clear: got %b want 0", err); end
   endtask

   task automatic test_random();
      int rb, lb, db, sb, acc; bit ok;
      logic [18:0] a;
      rb = req_a.size(); lb = line_d.size(); db = done_cnt; sb = stab_err;
      ready_mode = 2; max_gap = 5;
      issue(19'h7ff00, 16'd1000, acc);
      wait_done(db, 3000, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand_done_timeout: got none want pulse"); end
      vectors++; if (req_a.size() - rb !== 8) begin miscompares++; $display("FAIL rand_req_count: got %0d want 8", req_a.size() - rb); end
      for (int i = 0; i < 8; i++) begin
         if (rb + i < req_a.size()) begin
            a = 19'h7ff00 + 19'(i*128);
            vectors++;
            if (req_a[rb+i] !== a || req_s[rb+i] !== ((i == 7) ? 16'd104 : 16'd128)) begin
               miscompares++; $display("FAIL rand_req%0d: got %0h/%0d want %0h", i, req_a[rb+i], req_s[rb+i], a);
            end
         end
      end
      vectors++; if (stab_err - sb !== 0) begin miscompares++; $display("FAIL rand_req_stable: got %0d changes want 0", stab_err - sb); end
      vectors++; if (line_d.size() - lb !== 32) begin miscompares++; $display("FAIL rand_line_count: got %0d want 32", line_d.size() - lb); end
      for (int k = 0; k < 32; k++) begin
         if (lb + k < line_d.size()) begin
            a = 19'h7ff00 + 19'(k*32);
            vectors++;
            if (line_d[lb+k] !== pat(a) || line_l[lb+k] !== (k == 31) || line_b[lb+k] !== ((k == 31) ? 6'd8 : 6'd32)) begin
               miscompares++; $display("FAIL rand_line%0d: got last=%b bytes=%0d data=%0h", k, line_l[lb+k], line_b[lb+k], line_d[lb+k]);
            end
         end
      end
      vectors++; if (done_cnt - db !== 1) begin miscompares++; $display("FAIL rand_done_count: got %0d want 1", done_cnt - db); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_burst();
      test_backpressure();
      test_zero();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_line_reader.md
# mem_line_reader

Client-side read engine for the memory farm's `mem_intf_read` protocol: the requesting end that the farm's read ports answer. It accepts one transfer command (SRAM start address, byte count) from a compute engine (FCC/CNN/pool), splits it into bounded bursts, and drives `mem_req`/`mem_start_addr`/`mem_size_bytes`. It collects the returned 256-bit lines into an internal FIFO and presents them as a ready/valid stream with last-line byte count. It sits between a compute engine's data loader and one `mem_intf_read.memory_read` port of the farm.

## Interface
- `DEPTH`, 8: FIFO depth in 32-byte lines; power of two, ≥ `MAX_BURST_LINES`.
- `MAX_BURST_LINES`, 4: maximum lines per memory request.
- `SIZE_WIDTH`, 16: width of byte counts.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_addr` input 19: SRAM start byte address.
- `cmd_bytes` input SIZE_WIDTH: total bytes to read.
- `mem_req` output 1: request to memory; held until the burst completes.
- `mem_start_addr` output 19: burst start address; stable while `mem_req`.
- `mem_size_bytes` output SIZE_WIDTH: burst byte count; stable while `mem_req`.
- `mem_valid` input 1: one returned line this cycle.
- `mem_data` input 256: returned line, byte 0 in bits [7:0].
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts head.
- `out_data` output 256: FIFO head line.
- `out_bytes` output 6: valid bytes in head line, 1..32.
- `out_last` output 1: head is the final line of the command.
- `done` output 1: one-cycle pulse at command completion.
- `err` output 1: sticky protocol error (see Configuration).

## Operation
- States: IDLE, REQ, GAP, DONE. Reset: state IDLE, FIFO empty; all outputs 0 except `cmd_ready`=1.
- IDLE: on `cmd_valid` latch `rem`=`cmd_bytes`, `addr`=`cmd_addr`. `cmd_bytes`=0 → DONE, no request, no output line. Else → GAP.
- GAP: burst bytes `b`=min(`rem`, `MAX_BURST_LINES`×32), lines `L`=ceil(`b`/32). If FIFO free entries (`DEPTH`−occupancy, occupancy counted after this cycle's pop) ≥ `L`: load `mem_start_addr`=`addr`, `mem_size_bytes`=`b`, beat counter=`L`, → REQ. Otherwise stay in GAP.
- REQ: `mem_req`=1. Each `mem_valid` writes `mem_data` to FIFO tagged with bytes = 32, except the command's final line, tagged `rem` mod 32 (32 if 0), with last=1. On the final beat of the burst: `addr`+=`b`, `rem`−=`b`. Go to GAP if `rem`>0, else DONE.
- DONE: wait until FIFO empty (last line popped), pulse `done`, → IDLE.
- FIFO never overflows by construction (space reserved before request); `out_valid`=!empty.
- Address arithmetic is 19-bit wrap; counts are unsigned SIZE_WIDTH.

## Timing
- Command accepted edge N → `mem_req` high from N+2 (one GAP cycle) when FIFO has space.
- `mem_valid` at edge M → line at FIFO head visible (`out_valid`) from M+1 if FIFO was empty.
- `mem_req` falls the cycle after the final beat is sampled; at least one cycle low (GAP) between consecutive bursts.
- Beats may be non-contiguous; the engine waits indefinitely.
- Simultaneous push and pop supported every cycle; full FIFO with `out_ready`=1 still accepts a beat.
- `done` asserts the cycle after the `out_last` handshake (minimum); `cmd_ready` returns one cycle later.
- `rst` mid-transfer: next edge returns to reset values, FIFO flushed, `mem_req`=0; later-arriving beats are discarded.

## Configuration
- `MEM_LINE_READER_CHK_EN` defined: `err` sets (sticky until `rst`) on `mem_valid` while `mem_req`=0, or on `mem_valid` in the same cycle `mem_req` is first asserted (response before request was visible); offending beats are discarded.
- Not defined: checker absent, `err` tied 0, stray `mem_valid` ignored.

## Test plan
- `cmd_addr`=0x100, `cmd_bytes`=64, `out_ready`=1, memory returns 2 back-to-back beats → one request (size 64), 2 lines, second `out_last`=1, `out_bytes`=32, `done` once.
- `cmd_bytes`=200, DEPTH=8, MAX_BURST=4 → requests (0x0,128) then (0x80,72); 7 lines; last `out_bytes`=8.
- `out_ready`=0, `cmd_bytes`=320 → two bursts of 4 lines issued, third stalls in GAP (free=0) until pops; no beat lost; total 10 lines.
- `cmd_bytes`=0 → no `mem_req`, no `out_valid`, `done` pulse 2 cycles after accept.
- Assert `rst` mid-burst with 2 beats outstanding, then deliver them → FIFO empty, no `out_valid`; with `MEM_LINE_READER_CHK_EN`, `err`=1.
- Random `mem_valid` gaps (0–5 cycles) over 1000-byte command → data ordered and matching memory model; `mem_start_addr`/`mem_size_bytes` stable throughout each `mem_req`.
